seq_alu: RTL

- Parametrised, handshaked successor to the 16-bit combinational ALU.
- Keeps the same seven control bits (ci, nb, ic, zb, na, xo, no) for add/sub/xor/or/and/not/neg/inc/dec.
- Adds an iterative multi-cycle right-shift unit: logical, arithmetic and rotate.
- Sits between the decode stage and the register-file write-back. Input and output use valid/ready handshakes and results are registered.

---
 rtl/seq_alu_if.sv | 33 +++
 rtl/seq_alu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Handshake and operand bundle between the decode stage, seq_alu and write-back.
interface seq_alu_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic             ci;
   logic             nb;
   logic             ic;
   logic             zb;
   logic             na;
   logic             xo;
   logic             no;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             co;
   logic             zf;
   logic             nf;

   modport master (
      output in_valid, mode, ci, nb, ic, zb, na, xo, no, a, b, out_ready,
      input  in_ready, out_valid, out, co, zf, nf
   );

   modport slave (
      input  in_valid, mode, ci, nb, ic, zb, na, xo, no, a, b, out_ready,
      output in_ready, out_valid, out, co, zf, nf
   );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with the classic seven control bits plus an
// iterative one-bit-per-cycle right-shift unit (SRL / SRA / ROR).
// One operation in flight; results and flags are registered and held
// until the consumer takes them.
module seq_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst,
   seq_alu_if.slave  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] MODE_ALU = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
   localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [1:0]       op_mode;
   logic [WIDTH-1:0] sreg;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] res;
   logic             res_co;
   logic             res_zf;
   logic             res_nf;

   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] b1;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_r;
   logic [WIDTH-1:0] alu_out;
   logic             alu_co;
   logic [WIDTH-1:0] step_val;
   logic             step_co;
   logic [SHW-1:0]   shamt;

   // One right-shift step; the vacated MSB depends on the shift kind.
   function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (m)
         MODE_SRL: r = {1'b0, v[WIDTH-1:1]};
         MODE_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
         MODE_ROR: r = {v[0], v[WIDTH-1:1]};
         default:  r = v;
      endcase
      return r;
   endfunction

   // Zero flag of a result word.
   function automatic logic is_zero(input logic [WIDTH-1:0] v);
      return (v == {WIDTH{1'b0}});
   endfunction

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out       = res;
   assign bus.co        = res_co;
   assign bus.zf        = res_zf;
   assign bus.nf        = res_nf;
   assign shamt         = bus.b[SHW-1:0];

   // Combinational ALU datapath driven straight from the request operands.
   always_comb begin
      a1      = bus.na ? ~bus.a : bus.a;
      b0      = bus.zb ? {WIDTH{1'b0}} : bus.b;
      b1      = bus.nb ? ~b0 : b0;
      sum     = {1'b0, a1} + {1'b0, b1} + {{WIDTH{1'b0}}, bus.ci};
      alu_r   = {WIDTH{1'b0}};
      alu_co  = 1'b0;
      if (!bus.ic) begin
         alu_r  = sum[WIDTH-1:0];
         alu_co = sum[WIDTH];
      end else if (bus.xo) begin
         alu_r  = a1 | b1;
      end else begin
         alu_r  = a1 ^ b1;
      end
      alu_out = bus.no ? ~alu_r : alu_r;
   end

   // Next value of the shift register and the bit falling off its LSB.
   always_comb begin
      step_val = shift_one(op_mode, sreg);
      step_co  = sreg[0];
   end

   // Control FSM, shift engine and the held result/flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op_mode <= MODE_ALU;
         sreg    <= {WIDTH{1'b0}};
         cnt     <= CNT_ZERO;
         res     <= {WIDTH{1'b0}};
         res_co  <= 1'b0;
         res_zf  <= 1'b1;
         res_nf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.mode == MODE_ALU) begin
                     res    <= alu_out;
                     res_co <= alu_co;
                     res_zf <= is_zero(alu_out);
                     res_nf <= alu_out[WIDTH-1];
                     state  <= DONE;
                  end else begin
                     sreg    <= bus.a;
                     cnt     <= shamt;
                     op_mode <= bus.mode;
                     if (shamt == CNT_ZERO) begin
                        // Zero-length shift: the operand is the result, nothing shifted out.
                        res    <= bus.a;
                        res_co <= 1'b0;
                        res_zf <= is_zero(bus.a);
                        res_nf <= bus.a[WIDTH-1];
                        state  <= DONE;
                     end else begin
                        state  <= SHIFT;
                     end
                  end
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               sreg <= step_val;
               cnt  <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  // Last step: publish the result only now so out stays stable until then.
                  res    <= step_val;
                  res_co <= step_co;
                  res_zf <= is_zero(step_val);
                  res_nf <= step_val[WIDTH-1];
                  state  <= DONE;
               end else begin
                  state  <= SHIFT;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end else begin
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
